// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: alucontrol op
// codes it executes and the FSM state encoding.
package mdu_seq_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mdu_seq_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// WIDTH cycles after start, then done_o pulses for one cycle.
module mdu_seq_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    ge      = ~diff[WIDTH+1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], ge};
      cnt_q  <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning HI/LO, stalling EX while busy.
// Define MDU_DIVZERO_FAST_EN for a 2-cycle zero-divisor path and the divz_o port.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int OP_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic [1:0]       hilo_we_i,
  input  logic [WIDTH-1:0] hilo_wdata_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
`ifdef MDU_DIVZERO_FAST_EN
  ,
  output logic             divz_o
`endif
);

  localparam int CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   mcnt_q;
  logic [WIDTH-1:0]   a_q, hi_q, lo_q;
  logic               sign_a_q, sign_b_q, div_zero_q;
  logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];

  logic               is_mul_op, is_div_op, op_signed, start, div_start;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_full;
  logic [WIDTH-1:0]   a_mag, b_mag, div_quot, div_rem, div_hi, div_lo;
  logic               div_done, commit;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    is_mul_op = (op_i == OP_W'(EXE_MULT_OP)) || (op_i == OP_W'(EXE_MULTU_OP));
    is_div_op = (op_i == OP_W'(EXE_DIV_OP))  || (op_i == OP_W'(EXE_DIVU_OP));
    op_signed = (op_i == OP_W'(EXE_MULT_OP)) || (op_i == OP_W'(EXE_DIV_OP));
    start     = valid_i & ~flush_i & (state_q == ST_IDLE) & (is_mul_op | is_div_op);
    a_ext     = {{WIDTH{op_signed & a_i[WIDTH-1]}}, a_i};
    b_ext     = {{WIDTH{op_signed & b_i[WIDTH-1]}}, b_i};
    prod_full = a_ext * b_ext;
    a_mag     = (op_signed & a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag     = (op_signed & b_i[WIDTH-1]) ? -b_i : b_i;
  end

`ifdef MDU_DIVZERO_FAST_EN
  assign div_start = start & is_div_op & (b_i != '0);
`else
  assign div_start = start & is_div_op;
`endif

  mdu_seq_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .abort_i    (flush_i),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Sign-fix cycle: quotient negative iff signs differ, remainder follows dividend.
  always_comb begin
    div_lo = (sign_a_q ^ sign_b_q) ? -div_quot : div_quot;
    div_hi = sign_a_q ? -div_rem : div_rem;
    if (div_zero_q) begin
      div_lo = '1;
      div_hi = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    res_hi  = '0;
    res_lo  = '0;
    case (state_q)
      ST_IDLE: if (start) state_d = is_mul_op ? ST_MUL : ST_DIV;
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == CNT_W'(MUL_STAGES - 1)) begin
          commit  = 1'b1;
          res_hi  = pipe_q[MUL_STAGES-1][2*WIDTH-1:WIDTH];
          res_lo  = pipe_q[MUL_STAGES-1][WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_done
`ifdef MDU_DIVZERO_FAST_EN
                     || div_zero_q
`endif
                    ) begin
          commit  = 1'b1;
          res_hi  = div_hi;
          res_lo  = div_lo;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      mcnt_q     <= '0;
      a_q        <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= (state_q == ST_MUL) ? mcnt_q + CNT_W'(1) : '0;
      if (start) begin
        a_q        <= a_i;
        sign_a_q   <= op_signed & a_i[WIDTH-1];
        sign_b_q   <= op_signed & b_i[WIDTH-1];
        div_zero_q <= (b_i == '0);
      end
    end
  end

  // Product pipeline: stage 0 loads at the accept edge, later stages shift in MUL.
  for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pipe_q[gi] <= '0;
      end else if (gi == 0) begin
        if (start) pipe_q[gi] <= prod_full;
      end else if (state_q == ST_MUL) begin
        pipe_q[gi] <= pipe_q[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  // A completing op always beats an MTHI/MTLO on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == ST_IDLE || state_q == ST_DONE) begin
      if (hilo_we_i[1]) hi_q <= hilo_wdata_i;
      if (hilo_we_i[0]) lo_q <= hilo_wdata_i;
    end
  end

`ifdef MDU_DIVZERO_FAST_EN
  logic divz_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     divz_q <= 1'b0;
    else if (commit) divz_q <= (state_q == ST_DIV) & div_zero_q;
  end
  assign divz_o = divz_q & (state_q == ST_DONE);
`endif

  assign stall_o = ~flush_i & (start | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign done_o  = (state_q == ST_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq at WIDTH=32, MUL_STAGES=2; one task per scenario.
// Honours MDU_DIVZERO_FAST_EN for the zero-divisor latency and divz_o.
module tb_mdu_seq;

  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  logic        clk, resetn, valid_i, flush_i, stall_o, done_o;
  logic [7:0]  op_i;
  logic [31:0] a_i, b_i, hilo_wdata_i, hi_o, lo_o;
  logic [1:0]  hilo_we_i;
`ifdef MDU_DIVZERO_FAST_EN
  logic        divz_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mdu_seq #(.WIDTH(32), .MUL_STAGES(2), .OP_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .flush_i      (flush_i),
    .hilo_we_i    (hilo_we_i),
    .hilo_wdata_i (hilo_wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
`ifdef MDU_DIVZERO_FAST_EN
    ,
    .divz_o       (divz_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one op and runs until done_o; lat = cycles from accept to done_o (-1 on timeout).
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic stall_acc, output int nst);
    lat = -1;
    nst = 0;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    stall_acc = stall_o;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (done_o) begin
        lat = c;
        break;
      end
      if (stall_o) nst++;
    end
    $display("op=%h a=%h b=%h -> hi=%h lo=%h latency=%0d", op, a, b, hi_o, lo_o, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(2);
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'h0); end
    n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo_o, 32'h0); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    resetn = 1'b1;
    step(1);
    valid_i = 1'b1; op_i = 8'h20; a_i = 32'd1; b_i = 32'd2;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL nonmdu_stall: got %b expected 0", stall_o); end
    step(1);
    valid_i = 1'b0;
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL nonmdu_done: got %b expected 0", done_o); end
  endtask

  task automatic test_mult();
    int lat, nst; logic sa;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, sa, nst);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mult_latency: got %0d expected 3", lat); end
    n_checks++; if (sa !== 1'b1) begin n_fail++; $display("FAIL mult_stall_accept: got %b expected 1", sa); end
    n_checks++; if (nst != 2) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d expected 2", nst); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi_o, 32'hFFFF_FFFF); end
    n_checks++; if (lo_o !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo_o, 32'hFFFF_FFF1); end
    step(1);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", done_o); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, sa, nst);
    n_checks++; if (hi_o !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h expected %h", hi_o, 32'h1); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected %h", lo_o, 32'hFFFF_FFFE); end
    step(1);
  endtask

  task automatic test_div();
    int lat, nst; logic sa;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, sa, nst);
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", lat); end
    n_checks++; if (nst != 33) begin n_fail++; $display("FAIL div_stall_cycles: got %0d expected 33", nst); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected %h", lo_o, 32'hFFFF_FFFD); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected %h", hi_o, 32'hFFFF_FFFF); end
`ifdef MDU_DIVZERO_FAST_EN
    n_checks++; if (divz_o !== 1'b0) begin n_fail++; $display("FAIL div_divz: got %b expected 0", divz_o); end
`endif
    step(1);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, sa, nst);
    n_checks++; if (lo_o !== 32'h0000_000E) begin n_fail++; $display("FAIL divu_lo: got %h expected %h", lo_o, 32'hE); end
    n_checks++; if (hi_o !== 32'h0000_0002) begin n_fail++; $display("FAIL divu_hi: got %h expected %h", hi_o, 32'h2); end
    step(1);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, sa, nst);
    n_checks++; if (lo_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo: got %h expected %h", lo_o, 32'hFFFF_FFFD); end
    n_checks++; if (hi_o !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negb_hi: got %h expected %h", hi_o, 32'h1); end
    step(1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, sa, nst);
    n_checks++; if (lo_o !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", lo_o, 32'h8000_0000); end
    n_checks++; if (hi_o !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", hi_o, 32'h0); end
    step(1);
  endtask

  task automatic test_flush();
    int lat, nst, seen; logic sa;
    valid_i = 1'b1; op_i = OP_DIV; a_i = 32'd50; b_i = 32'd3;
    step(1);
    valid_i = 1'b0;
    step(9);
    flush_i = 1'b1;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
    step(1);
    flush_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (done_o) seen++;
      step(1);
    end
    $display("op=%h a=%h b=%h flushed at cycle 10 -> hi=%h lo=%h", OP_DIV, 32'd50, 32'd3, hi_o, lo_o);
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL flush_hi_kept: got %h expected %h", hi_o, 32'h0); end
    n_checks++; if (lo_o !== 32'h8000_0000) begin n_fail++; $display("FAIL flush_lo_kept: got %h expected %h", lo_o, 32'h8000_0000); end
    run_op(OP_MULTU, 32'd3, 32'd4, lat, sa, nst);
    n_checks++; if (lo_o !== 32'h0000_000C) begin n_fail++; $display("FAIL after_flush_lo: got %h expected %h", lo_o, 32'hC); end
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL after_flush_hi: got %h expected %h", hi_o, 32'h0); end
    step(1);
  endtask

  task automatic test_divzero();
    int lat, nst, exp_lat; logic sa;
`ifdef MDU_DIVZERO_FAST_EN
    exp_lat = 2;
`else
    exp_lat = 34;
`endif
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, lat, sa, nst);
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL divz_latency: got %0d expected %0d", lat, exp_lat); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected %h", lo_o, 32'hFFFF_FFFF); end
    n_checks++; if (hi_o !== 32'h0000_1234) begin n_fail++; $display("FAIL divz_hi: got %h expected %h", hi_o, 32'h1234); end
`ifdef MDU_DIVZERO_FAST_EN
    n_checks++; if (divz_o !== 1'b1) begin n_fail++; $display("FAIL divz_flag: got %b expected 1", divz_o); end
    step(1);
    n_checks++; if (divz_o !== 1'b0) begin n_fail++; $display("FAIL divz_flag_clear: got %b expected 0", divz_o); end
`else
    step(1);
`endif
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, sa, nst);
    n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_signed_lo: got %h expected %h", lo_o, 32'hFFFF_FFFF); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL divz_signed_hi: got %h expected %h", hi_o, 32'hFFFF_FFFB); end
    step(1);
  endtask

  task automatic test_hilo_write();
    hilo_we_i = 2'b01; hilo_wdata_i = 32'h0000_AAAA;
    step(1);
    hilo_we_i = 2'b00;
    $display("mtlo data=%h -> hi=%h lo=%h", 32'h0000_AAAA, hi_o, lo_o);
    n_checks++; if (lo_o !== 32'h0000_AAAA) begin n_fail++; $display("FAIL mtlo_lo: got %h expected %h", lo_o, 32'hAAAA); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected %h", hi_o, 32'hFFFF_FFFB); end
    hilo_we_i = 2'b10; hilo_wdata_i = 32'h0000_1357;
    step(1);
    hilo_we_i = 2'b00;
    $display("mthi data=%h -> hi=%h lo=%h", 32'h0000_1357, hi_o, lo_o);
    n_checks++; if (hi_o !== 32'h0000_1357) begin n_fail++; $display("FAIL mthi_hi: got %h expected %h", hi_o, 32'h1357); end
  endtask

  task automatic test_mthi_completion();
    int lat;
    lat = -1;
    valid_i = 1'b1; op_i = OP_MULT; a_i = 32'hFFFF_FFFE; b_i = 32'd3;
    step(1);
    valid_i = 1'b0;
    hilo_we_i = 2'b10; hilo_wdata_i = 32'h0000_5555;
    for (int c = 1; c <= 20; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      step(1);
    end
    $display("op=%h a=%h b=%h with mthi -> hi=%h lo=%h latency=%0d", OP_MULT, 32'hFFFF_FFFE, 32'd3, hi_o, lo_o, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mthi_mult_latency: got %0d expected 3", lat); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mthi_completion_hi: got %h expected %h", hi_o, 32'hFFFF_FFFF); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mthi_completion_lo: got %h expected %h", lo_o, 32'hFFFF_FFFA); end
    hilo_we_i = 2'b01; hilo_wdata_i = 32'h0000_2468;
    step(1);
    hilo_we_i = 2'b00;
    n_checks++; if (lo_o !== 32'h0000_2468) begin n_fail++; $display("FAIL mtlo_in_done_lo: got %h expected %h", lo_o, 32'h2468); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtlo_in_done_hi: got %h expected %h", hi_o, 32'hFFFF_FFFF); end
  endtask

  task automatic test_mt_with_start();
    int lat;
    lat = -1;
    valid_i = 1'b1; op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd4;
    hilo_we_i = 2'b01; hilo_wdata_i = 32'h0000_1111;
    step(1);
    valid_i = 1'b0; hilo_we_i = 2'b00;
    n_checks++; if (lo_o !== 32'h0000_1111) begin n_fail++; $display("FAIL mt_start_lo_first: got %h expected %h", lo_o, 32'h1111); end
    for (int c = 1; c <= 20; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      step(1);
    end
    $display("op=%h a=%h b=%h with mtlo -> hi=%h lo=%h latency=%0d", OP_MULTU, 32'd3, 32'd4, hi_o, lo_o, lat);
    n_checks++; if (lo_o !== 32'h0000_000C) begin n_fail++; $display("FAIL mt_start_lo_final: got %h expected %h", lo_o, 32'hC); end
    step(1);
  endtask

  task automatic test_done_ignores_start();
    int lat;
    lat = -1;
    valid_i = 1'b1; op_i = OP_MULTU; a_i = 32'd5; b_i = 32'd6;
    for (int c = 0; c <= 20; c++) begin
      #1;
      if (done_o) begin
        lat = c;
        break;
      end
      @(posedge clk);
    end
    $display("op=%h a=%h b=%h valid held -> hi=%h lo=%h latency=%0d", OP_MULTU, 32'd5, 32'd6, hi_o, lo_o, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL held_valid_latency: got %0d expected 3", lat); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL done_stall: got %b expected 0", stall_o); end
    n_checks++; if (lo_o !== 32'h0000_001E) begin n_fail++; $display("FAIL held_valid_lo: got %h expected %h", lo_o, 32'h1E); end
    valid_i = 1'b0;
    step(1);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_exit: got %b expected 0", done_o); end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    valid_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
    step(1);
    valid_i = 1'b0;
    step(4);
    resetn = 1'b0;
    #1;
    $display("reset during div -> hi=%h lo=%h stall=%b", hi_o, lo_o, stall_o);
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL midreset_hi: got %h expected %h", hi_o, 32'h0); end
    n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL midreset_lo: got %h expected %h", lo_o, 32'h0); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b expected 0", stall_o); end
    step(1);
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || stall_o) seen++;
      step(1);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midreset_idle: got %0d busy cycles expected 0", seen); end
  endtask

  initial begin
    resetn = 1'b0; valid_i = 1'b0; op_i = 8'h00; a_i = 32'h0; b_i = 32'h0;
    flush_i = 1'b0; hilo_we_i = 2'b00; hilo_wdata_i = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_divzero();
    test_hilo_write();
    test_mthi_completion();
    test_mt_with_start();
    test_done_ignores_start();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequential multiply/divide unit for the EX stage; executes MULT, MULTU, DIV and DIVU ops issued by the ALU decoder's alucontrol field.
- Owns the HI/LO architectural registers; MTHI/MTLO write them directly.
- Stalls the pipeline while an operation is in flight.
- Generalised over datapath width and multiplier pipeline depth.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, >=8)
- MUL_STAGES, 2, multiplier latency in cycles (1..4)
- OP_W, 8, width of the alucontrol op code

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- valid_i  in  1  EX-stage instruction valid
- op_i  in  OP_W  alucontrol code (EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP; others ignored)
- a_i  in  WIDTH  rs operand (dividend/multiplicand)
- b_i  in  WIDTH  rt operand (divisor/multiplier)
- flush_i  in  1  exception/flush: abort current op
- hilo_we_i  in  2  bit1 = MTHI, bit0 = MTLO write enable
- hilo_wdata_i  in  WIDTH  MTHI/MTLO data
- stall_o  out  1  hold the pipeline (combinational)
- done_o  out  1  one-cycle completion pulse
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE; hi_o = lo_o = 0; done_o = 0; all internal counters and registers 0.
- FSM states: IDLE, MUL, DIV, DONE.
- start = valid_i & !flush_i & (state==IDLE) & op_i in the MDU op set.
- IDLE -> MUL on MULT/MULTU; IDLE -> DIV on DIV/DIVU. Operands and signedness are latched at that edge.
- MUL: pipelined product; exits after MUL_STAGES cycles in MUL. HI = product[2W-1:W], LO = product[W-1:0]. Signed for MULT, unsigned for MULTU.
- DIV: radix-2 restoring divider on magnitudes, one quotient bit per cycle, WIDTH cycles, then one sign-fix cycle.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign (MIPS convention).
  - LO = quotient, HI = remainder.
  - -2^(W-1)/-1 gives LO = 0x80..0, HI = 0.
- Divide by zero (b=0), macro absent: full iteration; result LO = all ones, HI = a.
- HI/LO are written at the edge leaving MUL/DIV. The FSM then enters DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. start is ignored in DONE, since the same instruction is still in EX.
- stall_o = start | (state==MUL) | (state==DIV). It is low in DONE and whenever flush_i = 1.
- Latency, accept edge to done_o: MUL_STAGES+1 cycles for multiply; WIDTH+2 for divide (34 at W=32).
- flush_i in MUL/DIV: return to IDLE next edge; HI/LO unchanged; no done_o. flush_i in DONE: DONE still exits to IDLE; HI/LO are already committed.
- hilo_we_i is honoured only in IDLE or DONE, writing at the edge.
  - If it coincides with the completion edge, the MDU result wins.
  - If hilo_we_i and start occur in the same cycle, the MT write occurs and the op starts. The op result later overwrites it.
- Reset asserted mid-operation: immediate return to the reset state; the in-flight result is lost.

Optional Feature:
- Macro MDU_DIVZERO_FAST_EN.
- Defined:
  - A DIV/DIVU with b=0 skips iteration. It goes IDLE -> DIV for one cycle -> DONE: latency 2, stall high only in the accept cycle and the one DIV cycle.
  - Adds output port divz_o (1 bit), high together with done_o for a zero-divisor op.
  - Result values are as in the undefined case above.
- Undefined: no divz_o port; zero divisor takes the full WIDTH+2 latency.

Decomposition:
- Shared package/defines.vh: the MDU op codes (reuse the existing EXE_*_OP codes), the FSM state encoding localparams and an MDU op-set membership macro.
- Natural sub-module: mdu_div_iter, the restoring divider datapath (remainder/quotient shift registers plus counter, with start/busy/done). The multiplier stays inline as a registered product pipeline.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> done_o after 3 cycles (MUL_STAGES=2); HI=0xFFFFFFFF, LO=0xFFFFFFF1; stall_o high 2 cycles.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7, b=2 -> done_o at cycle 34; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIV started, flush_i pulsed at cycle 10 -> no done_o; HI/LO keep prior values; the next MULTU 3*4 gives LO=0x0000000C.
- DIVU b=0, a=0x1234 -> LO=0xFFFFFFFF, HI=0x00001234. Latency is 34 without the macro; 2 with it, plus divz_o=1.
- MTLO 0xAAAA in IDLE -> lo_o=0xAAAA next cycle. MTHI on the completion edge of a MULT -> HI equals the product high word. Reset mid-DIV -> hi_o=lo_o=0, stall_o=0.
